avalon_sram_bridge: RTL

AVALON_SRAM_BRIDGE -- requirements
Module: avalon_sram_bridge

---
 rtl/avalon_sram_bridge_pkg.sv | 21 ++
 rtl/avalon_sram_bridge_if.sv | 27 ++
 rtl/avalon_sram_bridge_fifo.sv | 59 +++++
 rtl/avalon_sram_bridge.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/avalon_sram_bridge_pkg.sv
// Shared types and default parameters for the Avalon-MM to asynchronous SRAM bridge.
package avalon_sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WTURN  = 2'd2
  } bridgeStateT;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_ADDR_W      = 18;
  localparam int DEF_CMD_DEPTH   = 4;
  localparam int DEF_RSP_DEPTH   = 4;
  localparam int DEF_WAIT_CYCLES = 1;

  // Counter width that stays legal (>=1 bit) for n == 1.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/avalon_sram_bridge_if.sv
// Avalon-MM side of the SRAM bridge; master drives commands, slave answers.
interface avalon_sram_bridge_if
  import avalon_sram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();
  localparam int BE_W = DATA_W / 8;

  logic              read_n;
  logic              write_n;
  logic [31:0]       address;
  logic [DATA_W-1:0] writeData;
  logic [BE_W-1:0]   byteEnable_n;
  logic [DATA_W-1:0] readData;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output read_n, write_n, address, writeData, byteEnable_n,
    input  readData, readdatavalid, waitrequest
  );

  modport slave (
    input  read_n, write_n, address, writeData, byteEnable_n,
    output readData, readdatavalid, waitrequest
  );
endinterface

// File: rtl/avalon_sram_bridge_fifo.sv
// SyncFifo: single-clock show-ahead FIFO; popData always presents the head entry.
module SyncFifo
  import avalon_sram_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = cntWidth(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic             doPush;
  logic             doPop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  // Head is read combinationally so the consumer sees the entry it is about to pop.
  assign popData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= (wrPtr == PTR_W'(DEPTH - 1)) ? '0 : wrPtr + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr <= (rdPtr == PTR_W'(DEPTH - 1)) ? '0 : rdPtr + PTR_W'(1);
      end
      unique case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/avalon_sram_bridge.sv
// Avalon-MM slave to asynchronous SRAM bridge: queued commands, fixed-length
// SRAM accesses with a write hold turn, in-order pipelined read responses.
module avalon_sram_bridge
  import avalon_sram_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int CMD_DEPTH   = DEF_CMD_DEPTH,
  parameter int RSP_DEPTH   = DEF_RSP_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int BE_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  avalon_sram_bridge_if.slave av,
  inout  wire  [DATA_W-1:0] dq_sram,
  output logic [ADDR_W-1:0] address_sram,
  output logic              ce_n_sram,
  output logic              oe_n_sram,
  output logic              we_n_sram,
  output logic [BE_W-1:0]   be_n_sram
);
  localparam int CMD_W  = 1 + ADDR_W + BE_W + DATA_W;
  localparam int WCNT_W = cntWidth(WAIT_CYCLES);
  localparam int OUT_W  = $clog2(RSP_DEPTH + 1);

  bridgeStateT       state;
  logic [WCNT_W-1:0] accessCnt;
  logic              curWrite;
  logic              driveDq;
  logic [DATA_W-1:0] wdataReg;
  logic              capValid;
  logic [DATA_W-1:0] capData;
  logic [OUT_W-1:0]  outstanding;

  logic              readOnly;
  logic              anyCmd;
  logic              waitReq;
  logic              cmdPush;
  logic              readAccept;
  logic [CMD_W-1:0]  cmdIn;
  logic [CMD_W-1:0]  cmdHead;
  logic              cmdEmpty;
  logic              cmdFull;
  logic              headWrite;
  logic [ADDR_W-1:0] headAddr;
  logic [BE_W-1:0]   headBe;
  logic [DATA_W-1:0] headData;
  logic              lastCycle;
  logic              readDone;
  logic              leaving;
  logic              startNext;
  logic [DATA_W-1:0] rspHead;
  logic              rspEmpty;
  logic              rdValid;
  logic              unusedRspFull;
  logic              unusedAddrHi;

  // A simultaneous read+write is a write, so only a pure read needs a response slot.
  assign readOnly   = !av.read_n && av.write_n;
  assign anyCmd     = !av.read_n || !av.write_n;
  assign waitReq    = rst || cmdFull || (readOnly && (outstanding == OUT_W'(RSP_DEPTH)));
  assign cmdPush    = anyCmd && !waitReq;
  assign readAccept = readOnly && !waitReq;
  assign cmdIn      = {!av.write_n, av.address[ADDR_W-1:0], av.byteEnable_n, av.writeData};
  assign {headWrite, headAddr, headBe, headData} = cmdHead;
  assign unusedAddrHi = ^av.address[31:ADDR_W];

  assign lastCycle = (accessCnt == WCNT_W'(WAIT_CYCLES - 1));
  assign readDone  = (state == ACCESS) && lastCycle && !curWrite;
  assign leaving   = readDone || (state == WTURN);
  assign startNext = !cmdEmpty && ((state == IDLE) || leaving);

  assign rdValid          = !rspEmpty && !rst;
  assign av.readdatavalid = rdValid;
  assign av.readData      = rdValid ? rspHead : '0;
  assign av.waitrequest   = waitReq;

  SyncFifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) cmdFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cmdPush),
    .pushData (cmdIn),
    .pop      (startNext),
    .popData  (cmdHead),
    .empty    (cmdEmpty),
    .full     (cmdFull)
  );

  SyncFifo #(.WIDTH(DATA_W), .DEPTH(RSP_DEPTH)) rspFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (capValid),
    .pushData (capData),
    .pop      (rdValid),
    .popData  (rspHead),
    .empty    (rspEmpty),
    .full     (unusedRspFull)
  );

  for (genvar gi = 0; gi < BE_W; gi++) begin : gLane
    assign dq_sram[gi*8 +: 8] = driveDq ? wdataReg[gi*8 +: 8] : 8'bz;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      unique case ({readAccept, rdValid})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: ;
      endcase
    end
  end

  // Strobes are registered alongside the state so they never glitch toward the SRAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      accessCnt    <= '0;
      curWrite     <= 1'b0;
      driveDq      <= 1'b0;
      wdataReg     <= '0;
      address_sram <= '0;
      ce_n_sram    <= 1'b1;
      oe_n_sram    <= 1'b1;
      we_n_sram    <= 1'b1;
      be_n_sram    <= '1;
      capValid     <= 1'b0;
      capData      <= '0;
    end else begin
      // Read data goes through a capture register before the response FIFO.
      capValid <= readDone;
      if (readDone) begin
        capData <= dq_sram;
      end
      if (startNext) begin
        state        <= ACCESS;
        accessCnt    <= '0;
        curWrite     <= headWrite;
        driveDq      <= headWrite;
        wdataReg     <= headData;
        address_sram <= headAddr;
        ce_n_sram    <= 1'b0;
        oe_n_sram    <= headWrite;
        we_n_sram    <= !headWrite;
        be_n_sram    <= headBe;
      end else if (leaving) begin
        state     <= IDLE;
        driveDq   <= 1'b0;
        ce_n_sram <= 1'b1;
        oe_n_sram <= 1'b1;
        we_n_sram <= 1'b1;
        be_n_sram <= '1;
      end else if (state == ACCESS) begin
        if (!lastCycle) begin
          accessCnt <= accessCnt + WCNT_W'(1);
        end else begin
          // Write hold turn: release we_n while address and data stay put.
          state     <= WTURN;
          we_n_sram <= 1'b1;
        end
      end
    end
  end
endmodule
